// File: rtl/eth_fifo_pkg.sv
// Shared types for the Ethernet TX frame FIFO: beat layout, write-FSM states, default depth.
package eth_fifo_pkg;

    localparam int DEPTH_DEFAULT = 512;
    localparam int DATA_W        = 64;
    localparam int KEEP_W        = DATA_W / 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic              user;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } wr_state_e;

endpackage

// File: rtl/eth_tx_frame_fifo_if.sv
// AXI-Stream beat bundle between DMA, frame FIFO and MAC; master drives the beat, slave drives tready.
interface eth_tx_frame_fifo_if;

    logic [eth_fifo_pkg::DATA_W-1:0] tdata;
    logic [eth_fifo_pkg::KEEP_W-1:0] tkeep;
    logic                            tlast;
    logic                            tuser;
    logic                            tvalid;
    logic                            tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tuser,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tuser,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/eth_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port (1-cycle read latency).
// No reset on storage or read register so it maps onto block RAM.
module eth_fifo_ram #(
    parameter int WIDTH = 74,
    parameter int DEPTH = 512
) (
    input  logic                     clock,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_dat_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_dat_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward TX frame FIFO in front of a 10G MAC; oversize frames are dropped (and, with
// ETH_TX_FIFO_ERR_DROP_EN, tuser-errored frames too). First beat out 2 cycles after commit; tready stalls only when full.
module eth_tx_frame_fifo
    import eth_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    eth_tx_frame_fifo_if.slave     s_axis,
    eth_tx_frame_fifo_if.master    m_axis,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [CNT_W-1:0]       drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // ---------------- write side ----------------
    wr_state_e        state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    wr_commit_q, wr_commit_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic  full;
    logic  oversize;
    logic  s_rdy;
    logic  ram_we;
    logic  drop_evt;
    beat_t wr_beat;

    assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    // Nothing committed is waiting, so the RAM is filled by the frame still being written.
    assign oversize = full && (wr_commit_q == rd_ptr_q);

    always_comb begin
        wr_beat.data = s_axis.tdata;
        wr_beat.keep = s_axis.tkeep;
        wr_beat.last = s_axis.tlast;
`ifdef ETH_TX_FIFO_ERR_DROP_EN
        wr_beat.user = 1'b0;
`else
        wr_beat.user = s_axis.tuser;
`endif
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        drop_d      = drop_q;
        s_rdy       = 1'b0;
        ram_we      = 1'b0;
        drop_evt    = 1'b0;
        unique case (state_q)
            ST_ACCEPT: begin
                s_rdy = !full;
                if (oversize) begin
                    wr_ptr_d = wr_commit_q;
                    drop_evt = 1'b1;
                    state_d  = ST_DROP;
                end else if (s_axis.tvalid && !full) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (s_axis.tlast) begin
`ifdef ETH_TX_FIFO_ERR_DROP_EN
                        if (s_axis.tuser) begin
                            wr_ptr_d = wr_commit_q;
                            drop_evt = 1'b1;
                        end else begin
                            wr_commit_d = wr_ptr_q + PW'(1);
                        end
`else
                        wr_commit_d = wr_ptr_q + PW'(1);
`endif
                    end
                end
            end
            ST_DROP: begin
                s_rdy = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
        if (drop_evt && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    assign s_axis.tready = s_rdy && resetn;

    // ---------------- read side ----------------
    // RAM read stage feeds an output register backed by one skid entry; reads are
    // issued only while the pair can absorb them, which keeps a full-rate stream.
    logic       rp_vld_q;
    logic       o_vld_q, o_vld_d;
    beat_t      o_dat_q, o_dat_d;
    logic       sk_vld_q, sk_vld_d;
    beat_t      sk_dat_q, sk_dat_d;
    beat_t      ram_rd_dat;
    logic       pop;
    logic       rd_issue;
    logic [1:0] occ;

    assign pop      = o_vld_q && m_axis.tready;
    assign occ      = 2'(o_vld_q) + 2'(sk_vld_q) + 2'(rp_vld_q) - 2'(pop);
    assign rd_issue = (rd_ptr_q != wr_commit_q) && (occ <= 2'd1);
    assign rd_ptr_d = rd_ptr_q + PW'(rd_issue);

    eth_fifo_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_dat_i  (wr_beat),
        .rd_en_i   (rd_issue),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_dat_o  (ram_rd_dat)
    );

    always_comb begin
        o_vld_d  = o_vld_q;
        o_dat_d  = o_dat_q;
        sk_vld_d = sk_vld_q;
        sk_dat_d = sk_dat_q;
        if (!o_vld_q || pop) begin
            if (sk_vld_q) begin
                o_vld_d  = 1'b1;
                o_dat_d  = sk_dat_q;
                sk_vld_d = rp_vld_q;
                if (rp_vld_q) begin
                    sk_dat_d = ram_rd_dat;
                end
            end else if (rp_vld_q) begin
                o_vld_d = 1'b1;
                o_dat_d = ram_rd_dat;
            end else begin
                o_vld_d = 1'b0;
            end
        end else if (rp_vld_q) begin
            sk_vld_d = 1'b1;
            sk_dat_d = ram_rd_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= ST_ACCEPT;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            drop_q      <= '0;
            rp_vld_q    <= 1'b0;
            o_vld_q     <= 1'b0;
            o_dat_q     <= '0;
            sk_vld_q    <= 1'b0;
            sk_dat_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            drop_q      <= drop_d;
            rp_vld_q    <= rd_issue;
            o_vld_q     <= o_vld_d;
            o_dat_q     <= o_dat_d;
            sk_vld_q    <= sk_vld_d;
            sk_dat_q    <= sk_dat_d;
        end
    end

    assign m_axis.tvalid = o_vld_q;
    assign m_axis.tdata  = o_dat_q.data;
    assign m_axis.tkeep  = o_dat_q.keep;
    assign m_axis.tlast  = o_dat_q.last;
`ifdef ETH_TX_FIFO_ERR_DROP_EN
    assign m_axis.tuser  = 1'b0;
`else
    assign m_axis.tuser  = o_dat_q.user;
`endif

    assign fill_level = wr_ptr_q - rd_ptr_q;
    assign drop_count = drop_q;

endmodule

// File: doc/eth_tx_frame_fifo.md
ETH_TX_FRAME_FIFO -- requirements
Module: eth_tx_frame_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 512, storage depth in 64-bit beats (power of 2, 64..4096).
REQ-002 SHALL provide parameter CNT_W, default 16, width of drop_count.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port: clock  in  1  sole clock; all logic rising-edge.
REQ-005 Port: resetn  in  1  synchronous active-low reset.
REQ-006 Port: s_axis_tdata/tkeep/tlast/tuser/tvalid  in  64/8/1/1/1  frame beats from the core-side DMA.
REQ-007 Port: s_axis_tready  out  1  upstream accept.
REQ-008 Port: m_axis_tdata/tkeep/tlast/tuser/tvalid  out  64/8/1/1/1  frame beats to the 10G MAC eth_tx_axis input.
REQ-009 Port: m_axis_tready  in  1  MAC accept.
REQ-010 Port: fill_level  out  $clog2(DEPTH)+1  beats currently stored, committed or not.
REQ-011 Port: drop_count  out  CNT_W  saturating count of discarded frames.

Function
REQ-012 Store-and-forward: a frame SHALL be visible on m_axis only after its tlast beat is accepted on s_axis.
REQ-013 Pointers wr_ptr, wr_commit, rd_ptr SHALL be $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = (wr_ptr-rd_ptr)==DEPTH.
REQ-014 Write FSM states: ACCEPT, DROP.
REQ-015 ACCEPT: s_axis_tready = !full; beat accepted on tvalid&&tready, written at wr_ptr, wr_ptr++.
REQ-016 Accepted tlast beat in ACCEPT SHALL set wr_commit to the incremented wr_ptr in the same cycle.
REQ-017 ACCEPT with full and wr_commit==rd_ptr (frame exceeds DEPTH) SHALL rewind wr_ptr to wr_commit, increment drop_count, enter DROP.
REQ-018 DROP: s_axis_tready=1, beats discarded; accepted tlast returns to ACCEPT.
REQ-019 Full with committed frames pending SHALL stall (tready=0), not drop.
REQ-020 Read side SHALL present data only while rd_ptr!=wr_commit; m_axis_tvalid SHALL never deassert mid-frame before tlast is accepted (no MAC underrun).
REQ-021 m_axis outputs SHALL be registered; first beat of a frame SHALL reach m_axis_tvalid within 2 cycles after the committing tlast acceptance, given an idle output.
REQ-022 With m_axis_tready held high, throughput SHALL be one beat per cycle, no bubbles within or between committed frames.
REQ-023 m_axis_* SHALL hold stable while tvalid&&!tready.
REQ-024 Simultaneous write, commit and read in one cycle SHALL all take effect; fill_level reflects both.
REQ-025 drop_count SHALL saturate at all-ones.

Reset
REQ-026 resetn low SHALL set all pointers 0, state ACCEPT, m_axis_tvalid 0, m_axis_tdata/tkeep/tlast/tuser 0, s_axis_tready 0 during reset, fill_level 0, drop_count 0.
REQ-027 Reset mid-frame SHALL discard partial and committed-but-unsent frames; first post-reset beat starts a new frame.

Configuration
REQ-028 Macro ETH_TX_FIFO_ERR_DROP_EN defined: tlast beat with s_axis_tuser=1 SHALL rewind wr_ptr to wr_commit (no commit), increment drop_count; m_axis_tuser tied 0; tuser not stored.
REQ-029 Macro undefined: tuser SHALL be stored per beat and forwarded unchanged; errored frames committed normally.

Structure
REQ-030 Shared package eth_fifo_pkg SHALL hold the beat struct (data, keep, last, user), write-FSM state enum, and DEPTH default constant.
REQ-031 One sub-module eth_fifo_ram: simple dual-port, one-cycle registered-read RAM, parameterised width/depth, inferrable as BRAM.

Verification
REQ-032 Reset, 3-beat frame (tkeep FF,FF,0F), m_axis_tready=1 -> m_axis_tvalid within 2 cycles of tlast, 3 consecutive beats, identical data/keep, fill_level returns 0.
REQ-033 Ten back-to-back 8-beat frames, MAC tready random 50% -> all 80 beats in order, tvalid never drops between first beat and tlast of any frame.
REQ-034 DEPTH=64, frame of 100 beats then 4-beat frame -> drop_count=1, only 4-beat frame emitted, s_axis_tready high during discarded tail.
REQ-035 With ETH_TX_FIFO_ERR_DROP_EN, frame A (tuser=1 on tlast) then frame B -> only B emitted, drop_count=1; without macro both emitted, A's tlast beat has m_axis_tuser=1.
REQ-036 resetn low for 1 cycle mid-frame with two frames committed -> m_axis_tvalid=0 next cycle, fill_level=0, next frame passes intact.
REQ-037 drop_count preset near max via 2^CNT_W+2 oversize frames (CNT_W=4) -> drop_count holds 15.
